// File: rtl/mon_pkg.sv
// Shared types and ASCII constants for the monitor hex-dump transmitter.
package mon_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DIGIT = 3'd1;
  localparam state_t ST_GSEP  = 3'd2;
  localparam state_t ST_WSEP  = 3'd3;
  localparam state_t ST_CR    = 3'd4;
  localparam state_t ST_LF    = 3'd5;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_CR       = 8'h0d;
  localparam logic [7:0] CH_LF       = 8'h0a;
  localparam logic [7:0] CH_DIGIT0   = 8'h30;
  localparam logic [7:0] CH_ALPHA_LO = 8'h61;
  localparam logic [7:0] CH_ALPHA_UP = 8'h41;

endpackage

// File: rtl/uart_send_hex_if.sv
// Word/line-control handshake and TX FIFO write port of uart_send_hex.
interface uart_send_hex_if #(parameter int DATA_W = 64);

  logic              word_valid;
  logic [DATA_W-1:0] word_data;
  logic              word_ready;
  logic              crlf_req;
  logic              busy;
  logic              line_done;
  logic [7:0]        send_char;
  logic              send_en;
  logic              tx_fifo_full;

  modport master (
    output word_valid, word_data, crlf_req, tx_fifo_full,
    input  word_ready, busy, line_done, send_char, send_en
  );

  modport slave (
    input  word_valid, word_data, crlf_req, tx_fifo_full,
    output word_ready, busy, line_done, send_char, send_en
  );

endinterface

// File: rtl/mon_hex_to_ascii.sv
// Nibble to ASCII hex digit. MON_HEX_UPPER_EN selects A-F instead of a-f.
module mon_hex_to_ascii
  import mon_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);

`ifdef MON_HEX_UPPER_EN
  localparam logic [7:0] ALPHA = CH_ALPHA_UP;
`else
  localparam logic [7:0] ALPHA = CH_ALPHA_LO;
`endif

  always_comb begin
    if (i_nib < 4'd10) o_char = CH_DIGIT0 + {4'd0, i_nib};
    else               o_char = ALPHA + {4'd0, i_nib} - 8'd10;
  end

endmodule

// File: rtl/uart_send_hex.sv
// Hex-dump transmitter: words in, grouped ASCII hex plus CR LF out to the TX FIFO.
// Letter case follows MON_HEX_UPPER_EN (see mon_hex_to_ascii).
module uart_send_hex
  import mon_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int GROUP_NIB      = 2,
  parameter int WORDS_PER_LINE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_send_hex_if.slave bus
);

  localparam int NIB  = DATA_W / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int GRP_W = (GROUP_NIB > 1) ? $clog2(GROUP_NIB) : 1;
  localparam int WC_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUP_NIB - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WORDS_PER_LINE - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [NIB_W-1:0]  r_nib_cnt;
  logic [GRP_W-1:0]  r_grp_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic              r_pending;

  logic       w_busy;
  logic       w_send_en;
  logic       w_crlf_now;
  logic [7:0] w_hex_char;
  logic [7:0] w_char;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_send_en  = w_busy & ~bus.tx_fifo_full;
  // A request arriving on the last-digit cycle still replaces the word separator.
  assign w_crlf_now = r_pending | bus.crlf_req;

  mon_hex_to_ascii u_hex (
    .i_nib  (r_shift[DATA_W-1 -: 4]),
    .o_char (w_hex_char)
  );

  always_comb begin
    w_char = CH_SPACE;
    case (r_state)
      ST_DIGIT: w_char = w_hex_char;
      ST_CR:    w_char = CH_CR;
      ST_LF:    w_char = CH_LF;
      default:  w_char = CH_SPACE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_nib_cnt  <= '0;
      r_grp_cnt  <= '0;
      r_word_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_busy && bus.crlf_req) r_pending <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (bus.word_valid) begin
            r_shift   <= bus.word_data;
            r_nib_cnt <= '0;
            r_grp_cnt <= '0;
            r_pending <= r_pending | bus.crlf_req;
            r_state   <= ST_DIGIT;
          end else if (w_crlf_now) begin
            r_state <= ST_CR;
          end
        end
        ST_DIGIT: begin
          if (w_send_en) begin
            r_shift <= r_shift << 4;
            if (r_nib_cnt == NIB_LAST) begin
              if (r_word_cnt == WC_LAST || w_crlf_now) begin
                r_state <= ST_CR;
              end else begin
                r_word_cnt <= r_word_cnt + WC_W'(1);
                r_state    <= ST_WSEP;
              end
            end else begin
              r_nib_cnt <= r_nib_cnt + NIB_W'(1);
              if (r_grp_cnt == GRP_LAST) begin
                r_grp_cnt <= '0;
                r_state   <= ST_GSEP;
              end else begin
                r_grp_cnt <= r_grp_cnt + GRP_W'(1);
              end
            end
          end
        end
        ST_GSEP: if (w_send_en) r_state <= ST_DIGIT;
        ST_WSEP: if (w_send_en) r_state <= ST_IDLE;
        ST_CR:   if (w_send_en) r_state <= ST_LF;
        ST_LF: begin
          if (w_send_en) begin
            r_word_cnt <= '0;
            r_pending  <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.word_ready = ~w_busy;
  assign bus.busy       = w_busy;
  assign bus.send_en    = w_send_en;
  assign bus.send_char  = w_char;
  assign bus.line_done  = (r_state == ST_LF) & w_send_en;

endmodule

// File: tb/tb_uart_send_hex.sv
// Directed bench for uart_send_hex: three configurations, exact character streams.
module tb_uart_send_hex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_send_hex_if #(.DATA_W(64)) ifa ();
  uart_send_hex_if #(.DATA_W(16)) ifb ();
  uart_send_hex_if #(.DATA_W(32)) ifc ();

  uart_send_hex #(.DATA_W(64), .GROUP_NIB(2), .WORDS_PER_LINE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  uart_send_hex #(.DATA_W(16), .GROUP_NIB(4), .WORDS_PER_LINE(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  uart_send_hex #(.DATA_W(32), .GROUP_NIB(2), .WORDS_PER_LINE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int errors = 0;
  int checks = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  int lda = 0, ldb = 0, ldc = 0;

  localparam string SA = "01 23 45 67 89 ab cd ef\015\012";

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.send_en) qa.push_back(ifa.send_char);
      if (ifb.send_en) qb.push_back(ifb.send_char);
      if (ifc.send_en) qc.push_back(ifc.send_char);
      if (ifa.line_done) lda++;
      if (ifb.line_done) ldb++;
      if (ifc.line_done) ldc++;
    end
  end

  function automatic logic [7:0] cx(logic [7:0] e);
`ifdef MON_HEX_UPPER_EN
    if (e >= 8'h61 && e <= 8'h66) return e - 8'h20;
`endif
    return e;
  endfunction

  function automatic logic busy_of(int w);
    case (w)
      0: return ifa.busy;
      1: return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(string tag, int w, string s);
    logic [7:0] q[$];
    case (w)
      0: q = qa;
      1: q = qb;
      default: q = qc;
    endcase
    chk({tag, ".len"}, 64'(q.size()), 64'(s.len()));
    for (int i = 0; i < s.len() && i < q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(q[i]), 64'(cx(s[i])));
  endtask

  task automatic wait_idle(int w, string tag);
    for (int i = 0; i < 400 && busy_of(w); i++) @(negedge clk);
    chk({tag, ".idle"}, 64'(busy_of(w)), 64'd0);
  endtask

  task automatic send_a(logic [63:0] d);
    wait_idle(0, "a_pre");
    ifa.word_data = d; ifa.word_valid = 1'b1;
    @(posedge clk); #1 ifa.word_valid = 1'b0;
  endtask

  task automatic send_c(logic [31:0] d);
    wait_idle(2, "c_pre");
    ifc.word_data = d; ifc.word_valid = 1'b1;
    @(posedge clk); #1 ifc.word_valid = 1'b0;
  endtask

  // mode 0: plain, 1: crlf_req with the word, 2: two crlf_req pulses during the word
  task automatic send_b(logic [15:0] d, int mode);
    for (int i = 0; i < 400 && !ifb.word_ready; i++) @(negedge clk);
    chk("b_ready", 64'(ifb.word_ready), 64'd1);
    ifb.word_data = d; ifb.word_valid = 1'b1; ifb.crlf_req = (mode == 1);
    @(posedge clk); #1 ifb.word_valid = 1'b0; ifb.crlf_req = 1'b0;
    if (mode == 2) begin
      ifb.crlf_req = 1'b1;
      @(posedge clk); #1 ifb.crlf_req = 1'b0;
      @(posedge clk); #1 ifb.crlf_req = 1'b1;
      @(posedge clk); #1 ifb.crlf_req = 1'b0;
    end
  endtask

  initial begin
    ifa.word_valid = 0; ifa.word_data = '0; ifa.crlf_req = 0; ifa.tx_fifo_full = 0;
    ifb.word_valid = 0; ifb.word_data = '0; ifb.crlf_req = 0; ifb.tx_fifo_full = 0;
    ifc.word_valid = 0; ifc.word_data = '0; ifc.crlf_req = 0; ifc.tx_fifo_full = 0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ifa.word_ready), 64'd1);
    chk("rst_busy",  64'(ifa.busy), 64'd0);
    chk("rst_en",    64'(ifa.send_en), 64'd0);
    chk("rst_ld",    64'(ifa.line_done), 64'd0);
    chk("rst_char",  64'(ifa.send_char), 64'h20);
    chk("rst_b_ready", 64'(ifb.word_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // cycle-exact default word
    qa.delete(); lda = 0;
    send_a(64'h0123456789ABCDEF);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      chk($sformatf("a_en@%0d", k), 64'(ifa.send_en), 64'(k <= 25));
      if (k <= 25) chk($sformatf("a_char@%0d", k), 64'(ifa.send_char), 64'(cx(SA[k-1])));
      chk($sformatf("a_ld@%0d", k), 64'(ifa.line_done), 64'(k == 25));
      chk($sformatf("a_rdy@%0d", k), 64'(ifa.word_ready), 64'(k == 26));
    end
    chk_q("a_stream", 0, SA);
    chk("a_ldcnt", 64'(lda), 64'd1);

    // backpressure for 3 cycles at character 5
    qa.delete(); lda = 0;
    send_a(64'h0123456789ABCDEF);
    repeat (4) @(posedge clk);
    #1 ifa.tx_fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_en", 64'(ifa.send_en), 64'd0);
      chk("bp_char", 64'(ifa.send_char), 64'h33);
    end
    @(posedge clk); #1 ifa.tx_fifo_full = 1'b0;
    wait_idle(0, "bp");
    chk_q("bp_stream", 0, SA);
    chk("bp_ldcnt", 64'(lda), 64'd1);

    // reset mid-word at character 7
    send_a(64'h0123456789ABCDEF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mr_en_before", 64'(ifa.send_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_en", 64'(ifa.send_en), 64'd0);
    chk("mr_busy", 64'(ifa.busy), 64'd0);
    chk("mr_ready", 64'(ifa.word_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    qa.delete(); lda = 0;
    send_a(64'hFEDCBA9876543210);
    wait_idle(0, "mr");
    chk_q("mr_stream", 0, "fe dc ba 98 76 54 32 10\015\012");

    // 32-bit default grouping
    qc.delete(); ldc = 0;
    send_c(32'h12AB34CD);
    wait_idle(2, "c");
    chk_q("c_stream", 2, "12 ab 34 cd\015\012");
    chk("c_ldcnt", 64'(ldc), 64'd1);

    // 16-bit, no intra-word spaces, two words per line
    qb.delete(); ldb = 0;
    send_b(16'hBEEF, 0); send_b(16'h0001, 0);
    wait_idle(1, "b1");
    chk_q("b1_stream", 1, "beef 0001\015\012");
    chk("b1_ldcnt", 64'(ldb), 64'd1);

    qb.delete(); ldb = 0;
    send_b(16'h1234, 2);
    wait_idle(1, "b2");
    chk_q("b2_stream", 1, "1234\015\012");
    chk("b2_ldcnt", 64'(ldb), 64'd1);

    qb.delete(); ldb = 0;
    send_b(16'h5678, 0); send_b(16'h9ABC, 0);
    wait_idle(1, "b3");
    chk_q("b3_stream", 1, "5678 9abc\015\012");
    chk("b3_ldcnt", 64'(ldb), 64'd1);

    qb.delete(); ldb = 0;
    ifb.crlf_req = 1'b1;
    @(posedge clk); #1 ifb.crlf_req = 1'b0;
    wait_idle(1, "b4");
    chk_q("b4_stream", 1, "\015\012");
    chk("b4_ldcnt", 64'(ldb), 64'd1);

    qb.delete(); ldb = 0;
    send_b(16'h1111, 0); send_b(16'h2222, 2);
    wait_idle(1, "b5");
    chk_q("b5_stream", 1, "1111 2222\015\012");
    chk("b5_ldcnt", 64'(ldb), 64'd1);

    qb.delete(); ldb = 0;
    send_b(16'hAAAA, 1);
    wait_idle(1, "b6");
    chk_q("b6_stream", 1, "aaaa\015\012");
    chk("b6_ldcnt", 64'(ldb), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_send_hex.md
# uart_send_hex

Parametrised monitor hex-dump transmitter for the UART monitor path. Accepts data words over a valid/ready handshake, renders each word as ASCII hex MSB-first with configurable digit grouping and words-per-line, and feeds the UART TX FIFO one character per cycle under `tx_fifo_full` backpressure. It terminates lines with CR LF, either automatically or on request, and pulses `line_done` so monitor control can flush its write queue.

## Interface
- `DATA_W`, 64: word width in bits. Must be a multiple of 4, range 4..128. `NIB = DATA_W/4`.
- `GROUP_NIB`, 2: digits per group, separated by one space. Range 1..NIB; `GROUP_NIB=NIB` means no intra-word spaces.
- `WORDS_PER_LINE`, 1: words per line before an automatic CR LF. Range 1..16.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `word_valid`  in  1  word offered
- `word_data`  in  DATA_W  word to print
- `word_ready`  out  1  block can accept a word (high only in IDLE)
- `crlf_req`  in  1  one-cycle request to end the current line
- `busy`  out  1  any state other than IDLE
- `line_done`  out  1  one-cycle pulse when the LF is accepted by the FIFO
- `send_char`  out  8  ASCII character to the TX FIFO
- `send_en`  out  1  write strobe to the TX FIFO
- `tx_fifo_full`  in  1  FIFO backpressure

## Operation
- States: IDLE, DIGIT, GSEP, WSEP, CR, LF.
- Word accept: in IDLE, when `word_valid` is high, `word_data` is loaded into a shift register, the nibble counter is cleared, and the FSM goes to DIGIT.
- DIGIT: emit the top nibble as hex (`0-9` = 0x30-0x39, `a-f` = 0x61-0x66), then shift left 4.
  - After each `GROUP_NIB`th digit that is not the last digit, go to GSEP. GSEP emits a space (0x20) and returns to DIGIT.
- After the last digit, increment `word_cnt`. Then:
  - If `word_cnt` reached `WORDS_PER_LINE`, or a CR LF is pending: go to CR.
  - Otherwise: go to WSEP, which emits a space and returns to IDLE.
- CR emits 0x0d, then LF emits 0x0a. On LF accept: pulse `line_done`, clear `word_cnt` and the pending flag, go to IDLE.
- `crlf_req` while in IDLE goes straight to CR, even when `word_cnt=0`, which produces an empty line.
- `crlf_req` while not in IDLE sets the pending flag. It is served after the current word in place of WSEP. A request that coincides with an automatic line end produces only one CR LF. Repeated requests while pending collapse into one.
- `word_valid` and `crlf_req` together in IDLE: the word is accepted and the CR LF is pending.
- Advance rule: an emitting state advances only when `send_en` is high.
  - `send_en = busy & ~tx_fifo_full`.
  - `send_char` is combinational from state and shift-register top nibble, and is held stable while stalled.

## Timing
- Reset values: state IDLE, `word_ready=1`, `busy=0`, `send_en=0`, `line_done=0`, `send_char=0x20`, all counters 0, pending flag 0.
- Accept at cycle T: first character is presented at T+1.
- Characters per word: `NIB + ceil(NIB/GROUP_NIB) - 1`, plus 1 (WSEP) or 2 (CR LF).
- Defaults, no backpressure: 25 characters, `send_en` high T+1..T+25, `line_done` at T+25, `word_ready` high again at T+26.
- There is no bubble between characters while the FIFO is not full.
- Backpressure on any cycle freezes the state and counters. No character is dropped or duplicated.
- A reset assertion mid-word aborts immediately. The partial line is not terminated.

## Configuration
- `MON_HEX_UPPER_EN` defined: hex digits a-f are emitted as 0x41-0x46 (`A-F`).
- Not defined: a-f are emitted as lowercase 0x61-0x66.
- Nothing else changes.

## Structure
- Package `mon_pkg`: FSM state typedef, ASCII constants (SPACE 0x20, CR 0x0d, LF 0x0a, DIGIT0 0x30, ALPHA 0x61/0x41).
- Sub-module `mon_hex_to_ascii`: combinational 4-bit nibble to 8-bit ASCII, contains the `MON_HEX_UPPER_EN` switch.
- Counters are sized with `$clog2` of NIB, GROUP_NIB and WORDS_PER_LINE.

## Test plan
- DATA_W=32, defaults, word 0x12AB34CD -> "12 ab 34 cd" CR LF: 13 characters 0x31 0x32 0x20 0x61 0x62 0x20 0x33 0x34 0x20 0x63 0x64 0x0d 0x0a, `line_done` on the LF cycle, `word_ready` high one cycle later.
- Same stimulus with `MON_HEX_UPPER_EN` -> 0x41 0x42 and 0x43 0x44 replace the lowercase letters. No other character changes.
- DATA_W=16, GROUP_NIB=4, WORDS_PER_LINE=2, words 0xBEEF then 0x0001 -> "beef 0001" CR LF. Exactly one `line_done` pulse.
- Defaults, word 0x0123456789ABCDEF, `tx_fifo_full` high for 3 cycles at character 5 -> `send_en` low for 3 cycles, `send_char` held at 0x33. Full 25-character stream intact.
- WORDS_PER_LINE=4, `crlf_req` pulsed during word 1 -> CR LF follows word 1 with no trailing space, and `word_cnt` restarts. `crlf_req` in IDLE -> lone CR LF.
- `rst_n` asserted at character 7 -> `send_en` drops asynchronously. After release: IDLE, `word_ready=1`, and the next word prints from its MSB digit.
